// File: rtl/lane_ser_pkg.sv
// Shared definitions for the 4x8 lane serializer: lane geometry, FSM state type
// and a lane-extraction helper.
package lane_ser_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int WORD_W    = LANE_W * NUM_LANES;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Lane 0 sits in the least significant byte of the stored word.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
        lane_sel = word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/lane_word_fifo.sv
// Word buffer for the lane serializer: FIFO_DEPTH entries (power of two) of
// width bits, with an occupancy counter that drives full/empty.
module lane_word_fifo #(
    parameter int width      = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Requests against a full or empty buffer are ignored here as a safety net.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lane_serializer_4x8.sv
// Buffers 32-bit words from four byte lanes and streams them out lane0..lane3
// with valid/ready flow control. Optional even parity output: LANE_SER_PARITY_EN.
module lane_serializer_4x8
    import lane_ser_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       fifo_full,
`ifdef LANE_SER_PARITY_EN
    output logic       parity_out,
`endif
    output logic       fifo_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. Input side: valid_in/ready_out. Output side: valid_out/ready_in;
    // data_out and valid_out hold while valid_out=1 and ready_in=0.

    ser_state_t        state;
    ser_state_t        state_nxt;
    logic [1:0]        idx;
    logic [1:0]        idx_nxt;
    logic [LANE_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              advance;
    logic              push;
    logic              pop;
    logic              have_word;
    logic [WORD_W-1:0] head;
    logic [CW-1:0]     occupancy;
    logic              full_w;
    logic              empty_w;

    assign ready_out  = !full_w;
    assign push       = valid_in && ready_out;
    assign fifo_full  = full_w;
    assign fifo_empty = empty_w;
    assign have_word  = (occupancy != '0);
    assign advance    = !valid_out || ready_in;

    lane_word_fifo #(
        .width      (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({data_in3, data_in2, data_in1, data_in0}),
        .rdata (head),
        .count (occupancy),
        .full  (full_w),
        .empty (empty_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
        end
    end

    // idx is the lane to load on the next advance; 0 in SEND means lane3 has
    // just been loaded and the head word already popped.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        data_nxt  = data_out;
        valid_nxt = valid_out;
        pop       = 1'b0;
        if (advance) begin
            case (state)
                IDLE: begin
                    if (have_word) begin
                        data_nxt  = lane_sel(head, 2'd0);
                        valid_nxt = 1'b1;
                        idx_nxt   = 2'd1;
                        state_nxt = SEND;
                    end else begin
                        data_nxt  = IDLE_BYTE;
                        valid_nxt = 1'b0;
                    end
                end
                SEND: begin
                    if (idx != 2'd0) begin
                        data_nxt  = lane_sel(head, idx);
                        valid_nxt = 1'b1;
                        idx_nxt   = idx + 2'd1;
                        pop       = (idx == 2'd3);
                    end else if (have_word) begin
                        data_nxt  = lane_sel(head, 2'd0);
                        valid_nxt = 1'b1;
                        idx_nxt   = 2'd1;
                    end else begin
                        data_nxt  = IDLE_BYTE;
                        valid_nxt = 1'b0;
                        idx_nxt   = 2'd0;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    data_nxt  = IDLE_BYTE;
                    valid_nxt = 1'b0;
                    idx_nxt   = 2'd0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef LANE_SER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_out <= 1'b0;
        end else begin
            parity_out <= valid_nxt ? ^data_nxt : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lane_serializer_4x8.sv
// Directed bench for lane_serializer_4x8: expected bytes are queued as words are
// pushed and checked as the DUT hands them downstream.
module tb_lane_serializer_4x8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       fifo_full;
    logic       fifo_empty;
`ifdef LANE_SER_PARITY_EN
    logic       parity_out;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    lane_serializer_4x8 dut (
        .clk        (clk),
        .reset      (reset),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .fifo_full  (fifo_full),
`ifdef LANE_SER_PARITY_EN
        .parity_out (parity_out),
`endif
        .fifo_empty (fifo_empty)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: called just after a rising edge, returns just after the push edge
    task automatic push_word(input logic [31:0] w, input logic exp_acc);
        data_in0 = w[7:0];
        data_in1 = w[15:8];
        data_in2 = w[23:16];
        data_in3 = w[31:24];
        valid_in = 1'b1;
        @(negedge clk);
        chk("ready_out", {31'd0, ready_out}, {31'd0, exp_acc});
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (exp_acc) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!valid_out && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_drained"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle_byte"}, {24'd0, data_out}, 32'hBC);
        step();
    endtask

    // scoreboard: a byte leaves on each edge where valid_out and ready_in are high
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL stray_byte observed=%0h expected=none", data_out);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("stream_byte", {24'd0, data_out}, {24'd0, mon_exp});
`ifdef LANE_SER_PARITY_EN
                chk("stream_parity", {31'd0, parity_out}, {31'd0, ^mon_exp});
`endif
            end
        end
    end

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'hBC);
        chk("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_ready_out", {31'd0, ready_out}, 32'd1);
`ifdef LANE_SER_PARITY_EN
        chk("rst_parity", {31'd0, parity_out}, 32'd0);
`endif
        step();
        reset = 1'b0;
        step();

        // single word and latency
        push_word(32'h44332211, 1'b1);
        @(negedge clk);
        chk("lat_before", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        chk("lat_lane0_valid", {31'd0, valid_out}, 32'd1);
        chk("lat_lane0_data", {24'd0, data_out}, 32'h11);
        repeat (4) @(negedge clk);
        chk("single_end_valid", {31'd0, valid_out}, 32'd0);
        chk("single_end_data", {24'd0, data_out}, 32'hBC);
        step();
        wait_idle("single");

        // back-pressure while lane1 is shown
        push_word(32'h44332211, 1'b1);
        step();
        step();
        chk("bp_lane1", {24'd0, data_out}, 32'h22);
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", {24'd0, data_out}, 32'h22);
            chk("bp_hold_valid", {31'd0, valid_out}, 32'd1);
        end
        step();
        ready_in = 1'b1;
        wait_idle("bp");

        // fill with downstream stalled; fifth word is dropped
        ready_in = 1'b0;
        push_word(32'hA3A2A1A0, 1'b1);
        push_word(32'hB3B2B1B0, 1'b1);
        push_word(32'hC3C2C1C0, 1'b1);
        push_word(32'hD3D2D1D0, 1'b1);
        @(negedge clk);
        chk("fill_full", {31'd0, fifo_full}, 32'd1);
        step();
        push_word(32'hE3E2E1E0, 1'b0);
        @(negedge clk);
        chk("fill_full_after", {31'd0, fifo_full}, 32'd1);
        chk("fill_count", {28'd0, dut.u_fifo.count}, 32'd4);
        step();
        ready_in = 1'b1;
        wait_idle("fill");
        chk("fill_empty", {31'd0, fifo_empty}, 32'd1);

        // back-to-back words: eight valid bytes with no bubble
        push_word(32'h13121110, 1'b1);
        push_word(32'h17161514, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b_valid", {31'd0, valid_out}, 32'd1);
        end
        @(negedge clk);
        chk("b2b_gap_end", {31'd0, valid_out}, 32'd0);
        chk("b2b_empty", {31'd0, fifo_empty}, 32'd1);
        step();
        wait_idle("b2b");

        // reset while lane2 is on the output, with a second word buffered
        push_word(32'hDDCCBBAA, 1'b1);
        push_word(32'h88776655, 1'b1);
        step();
        step();
        chk("rst_mid_lane2", {24'd0, data_out}, 32'hCC);
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_mid_data", {24'd0, data_out}, 32'hBC);
        chk("rst_mid_empty", {31'd0, fifo_empty}, 32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", {31'd0, valid_out}, 32'd0);
        end
        step();

        // random words with random downstream stalls
        for (int n = 0; n < 3; n++) begin
            ready_in = 1'($urandom_range(0, 1));
            push_word($urandom, 1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            ready_in = 1'($urandom_range(0, 1));
            step();
        end
        ready_in = 1'b1;
        wait_idle("rand");

`ifdef LANE_SER_PARITY_EN
        // parity of lane0=07 and lane1=03
        push_word(32'h00000307, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("parity_07", {31'd0, parity_out}, 32'd1);
        @(negedge clk);
        chk("parity_03", {31'd0, parity_out}, 32'd0);
        step();
        wait_idle("parity");
        chk("parity_idle", {31'd0, parity_out}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lane_serializer_4x8.md
LANE_SERIALIZER_4X8 -- requirements
Module: lane_serializer_4x8

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 32-bit words buffered; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter IDLE_BYTE, default 8'hBC, giving the data_out value whenever valid_out=0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports data_in0, data_in1, data_in2, data_in3, input, 8 bits each: lane bytes from the upstream recirculation demux mux-path outputs.
REQ-006 The block SHALL have port valid_in, input, 1 bit: the four lane bytes form a valid word this cycle.
REQ-007 The block SHALL have port ready_out, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port data_out, output, 8 bits: the serialized byte stream.
REQ-009 The block SHALL have port valid_out, output, 1 bit: data_out carries a valid byte.
REQ-010 The block SHALL have port ready_in, input, 1 bit: downstream accepts data_out this cycle.
REQ-011 The block SHALL have ports fifo_full and fifo_empty, output, 1 bit each: word-buffer status.
REQ-012 The block SHALL have port parity_out, output, 1 bit, present only with LANE_SER_PARITY_EN.

Function
REQ-013 The block SHALL accept a word (push) on a rising edge only when valid_in=1 and ready_out=1, storing {data_in3,data_in2,data_in1,data_in0}.
REQ-014 The block SHALL drive ready_out = !fifo_full combinationally from registered occupancy; a pop in the same cycle SHALL NOT enable a push when full.
REQ-015 The block SHALL drop valid_in=1 with ready_out=0 without side effects.
REQ-016 The block SHALL hold occupancy in a counter of width $clog2(FIFO_DEPTH)+1, with fifo_full = (count==FIFO_DEPTH) and fifo_empty = (count==0), both registered-derived.
REQ-017 The serializer SHALL be an FSM with states IDLE and SEND and a 2-bit byte index (0..3).
REQ-018 The output register SHALL advance when (valid_out==0 || ready_in==1); otherwise data_out and valid_out SHALL hold.
REQ-019 On advance in IDLE with fifo_empty=0, the FSM SHALL load lane0 of the head word, set valid_out=1, set index=1, and go to SEND.
REQ-020 On advance in SEND, the FSM SHALL output lanes in order lane0, lane1, lane2, lane3; the head word SHALL be popped on the advance that loads lane3.
REQ-021 On advance after lane3, the FSM SHALL load lane0 of the next word back-to-back with no bubble if the FIFO is non-empty; otherwise it SHALL set valid_out=0, set data_out=IDLE_BYTE, and return to IDLE.
REQ-022 Latency SHALL be: a word pushed at edge N into an empty block gives lane0 valid after edge N+1.
REQ-023 Sustained throughput SHALL be 1 byte/cycle with ready_in=1; one word per 4 cycles is sustainable indefinitely.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, and read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 While reset=1, asynchronously: count=0, pointers=0, state=IDLE, index=0, valid_out=0, data_out=IDLE_BYTE, fifo_empty=1, fifo_full=0, ready_out=1, parity_out=0.
REQ-026 A reset mid-word SHALL discard buffered and partially sent words, with no output after deassertion until a new push.

Configuration
REQ-027 With LANE_SER_PARITY_EN defined, parity_out SHALL be registered alongside data_out and equal to ^data_out (even parity), and 0 when valid_out=0.
REQ-028 Without LANE_SER_PARITY_EN, the parity_out port and its logic SHALL be absent.

Structure
REQ-029 A shared package lane_ser_pkg SHALL hold the FSM state typedef (IDLE, SEND), LANE_W=8, and NUM_LANES=4.
REQ-030 The word buffer SHALL be a sub-module lane_word_fifo (parameters width=32 and FIFO_DEPTH; push, pop, count, full, empty).

Verification
REQ-031 Single word: after reset, push {8'h44,8'h33,8'h22,8'h11} with ready_in=1 -> data_out is 11,22,33,44 on 4 consecutive cycles, then valid_out=0 and data_out=8'hBC.
REQ-032 Back-pressure: ready_in=0 for 3 cycles while lane1 (8'h22) is shown -> data_out holds 8'h22 and valid_out holds 1; the sequence resumes with no loss or duplication.
REQ-033 Fill: push 5 words with ready_in=0 -> the first 4 are accepted, fifo_full=1 and ready_out=0 on the 5th; the 5th is dropped and count stays 4.
REQ-034 Back-to-back: push 2 words with ready_in=1 -> 8 consecutive valid bytes with no bubble, then fifo_empty=1.
REQ-035 Reset mid-word: assert reset while lane2 is output -> valid_out=0, data_out=8'hBC, and fifo_empty=1 immediately; no stale bytes appear after release.
REQ-036 Parity (LANE_SER_PARITY_EN): byte 8'h07 -> parity_out=1; byte 8'h03 -> parity_out=0.
